// File: rtl/r_resp_arbiter.sv
// rtl/r_resp_arbiter.sv - round-robin, burst-locked merge of AXI R beats into one registered stream
module r_resp_arbiter #(
   parameter int NUM_SRC    = 4,
   parameter int ID_WIDTH   = 32,
   parameter int DATA_WIDTH = 64,
   parameter int RESP_WIDTH = 2,
   localparam int IDX_W     = $clog2(NUM_SRC)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_SRC-1:0]             in_valid,
   output logic [NUM_SRC-1:0]             in_ready,
   input  logic [NUM_SRC*ID_WIDTH-1:0]    in_id,
   input  logic [NUM_SRC*DATA_WIDTH-1:0]  in_data,
   input  logic [NUM_SRC*RESP_WIDTH-1:0]  in_resp,
   input  logic [NUM_SRC-1:0]             in_last,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [ID_WIDTH-1:0]            out_id,
   output logic [DATA_WIDTH-1:0]          out_data,
   output logic [RESP_WIDTH-1:0]          out_resp,
   output logic                           out_last,
   output logic                           busy,
   output logic [IDX_W-1:0]               owner
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   state_t                  state_q;
   logic [IDX_W-1:0]        rr_ptr_q;
   logic [IDX_W-1:0]        rr_ptr_d;
   logic [IDX_W-1:0]        owner_q;
   logic                    out_valid_q;
   logic [ID_WIDTH-1:0]     out_id_q;
   logic [DATA_WIDTH-1:0]   out_data_q;
   logic [RESP_WIDTH-1:0]   out_resp_q;
   logic                    out_last_q;

   logic [IDX_W-1:0]        sel;
   logic                    sel_valid;
   logic                    slot_free;
   logic                    accept;
   int                      scan_sum;
   logic [IDX_W-1:0]        scan_idx;
   logic [ID_WIDTH-1:0]     sel_id;
   logic [DATA_WIDTH-1:0]   sel_data;
   logic [RESP_WIDTH-1:0]   sel_resp;
   logic                    sel_last;

   assign slot_free = ~out_valid_q | out_ready;

   // Scan downward so the valid source nearest rr_ptr_q is the last write and wins.
   always_comb begin
      sel       = owner_q;
      sel_valid = 1'b0;
      scan_sum  = 0;
      scan_idx  = '0;
      if (state_q == ST_BURST) begin
         sel_valid = in_valid[owner_q];
      end else begin
         for (int k = NUM_SRC - 1; k >= 0; k--) begin
            scan_sum = int'(rr_ptr_q) + k;
            if (scan_sum >= NUM_SRC) begin
               scan_sum = scan_sum - NUM_SRC;
            end
            scan_idx = IDX_W'(scan_sum);
            if (in_valid[scan_idx]) begin
               sel       = scan_idx;
               sel_valid = 1'b1;
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      sel_id   = '0;
      sel_data = '0;
      sel_resp = '0;
      sel_last = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sel == IDX_W'(i)) begin
            in_ready[i] = rst & slot_free & sel_valid;
            sel_id      = in_id[i*ID_WIDTH +: ID_WIDTH];
            sel_data    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            sel_resp    = in_resp[i*RESP_WIDTH +: RESP_WIDTH];
            sel_last    = in_last[i];
         end
      end
   end

   assign accept   = |in_ready;
   assign rr_ptr_d = (sel == IDX_W'(NUM_SRC - 1)) ? '0 : sel + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         out_valid_q <= 1'b0;
         out_id_q    <= '0;
         out_data_q  <= '0;
         out_resp_q  <= '0;
         out_last_q  <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_id_q    <= sel_id;
         out_data_q  <= sel_data;
         out_resp_q  <= sel_resp;
         out_last_q  <= sel_last;
         owner_q     <= sel;
         if (sel_last) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= rr_ptr_d;
         end else begin
            state_q  <= ST_BURST;
         end
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign out_id    = out_id_q;
   assign out_data  = out_data_q;
   assign out_resp  = out_resp_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q == ST_BURST);
   assign owner     = owner_q;

endmodule

// File: tb/tb_r_resp_arbiter.sv
// tb/tb_r_resp_arbiter.sv - randomized and directed bench for r_resp_arbiter against a beat-level model
module tb_r_resp_arbiter;

   localparam int N  = 4;
   localparam int IW = 32;
   localparam int DW = 64;
   localparam int RW = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N-1:0]    in_valid = '0;
   logic [N-1:0]    in_ready;
   logic [N*IW-1:0] in_id = '0;
   logic [N*DW-1:0] in_data = '0;
   logic [N*RW-1:0] in_resp = '0;
   logic [N-1:0]    in_last = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [IW-1:0]   out_id;
   logic [DW-1:0]   out_data;
   logic [RW-1:0]   out_resp;
   logic            out_last;
   logic            busy;
   logic [1:0]      owner;

   always #5 clk = ~clk;

   r_resp_arbiter #(
      .NUM_SRC    (N),
      .ID_WIDTH   (IW),
      .DATA_WIDTH (DW),
      .RESP_WIDTH (RW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_id     (in_id),
      .in_data   (in_data),
      .in_resp   (in_resp),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_id    (out_id),
      .out_data  (out_data),
      .out_resp  (out_resp),
      .out_last  (out_last),
      .busy      (busy),
      .owner     (owner)
   );

   int total = 0;
   int bad   = 0;

   // Source side: each source owns a count of bursts still to send and walks through their beats.
   int       pend[N];
   int       blen[N];
   int       bidx[N];
   int       seq[N];
   int       fix_len[N];
   bit [N-1:0] gate;

   // Reference: lock flag, lock owner, round-robin start point and the single output slot.
   bit            m_lock;
   bit            m_ov;
   int            m_own;
   int            m_ptr;
   logic [IW-1:0] m_id;
   logic [DW-1:0] m_data;
   logic [RW-1:0] m_resp;
   logic          m_last;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick_len(input int i);
      return (fix_len[i] != 0) ? fix_len[i] : int'($urandom_range(4, 1));
   endfunction

   task automatic set_src(input int i, input int n, input int len);
      pend[i]    = n;
      fix_len[i] = len;
      blen[i]    = pick_len(i);
      bidx[i]    = 0;
      gate[i]    = 1'b1;
   endtask

   function automatic bit any_pend();
      for (int i = 0; i < N; i++) begin
         if (pend[i] > 0) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         in_valid[i]          = (pend[i] > 0) && gate[i];
         in_id[i*IW +: IW]    = IW'(seq[i] * 16 + i);
         in_data[i*DW +: DW]  = {32'(seq[i]) ^ 32'hC0DE_0000, 32'(i * 7 + 1)};
         in_resp[i*RW +: RW]  = RW'(seq[i]);
         in_last[i]           = (bidx[i] == blen[i] - 1);
      end
   endtask

   task automatic model_reset();
      m_lock = 1'b0;
      m_ov   = 1'b0;
      m_own  = 0;
      m_ptr  = 0;
      m_id   = '0;
      m_data = '0;
      m_resp = '0;
      m_last = 1'b0;
   endtask

   // One clock: drive, check at the falling edge, then advance model and sources at the rising edge.
   task automatic step();
      int            sel;
      logic [N-1:0]  exp_rdy;
      logic [IW-1:0] c_id;
      logic [DW-1:0] c_data;
      logic [RW-1:0] c_resp;
      logic          c_last;
      drive_inputs();
      @(negedge clk);
      sel = -1;
      if (m_lock) begin
         if (in_valid[m_own]) sel = m_own;
      end else begin
         for (int d = 0; d < N && sel < 0; d++) begin
            if (in_valid[(m_ptr + d) % N]) sel = (m_ptr + d) % N;
         end
      end
      exp_rdy = '0;
      if (sel >= 0 && (!m_ov || out_ready)) exp_rdy = N'(1) << sel;
      check_eq("in_ready", in_ready, exp_rdy);
      check_eq("out_valid", out_valid, m_ov);
      check_eq("busy", busy, m_lock);
      check_eq("owner", owner, m_own);
      if (m_ov) begin
         check_eq("out_id", out_id, m_id);
         check_eq("out_data", out_data, m_data);
         check_eq("out_resp", out_resp, m_resp);
         check_eq("out_last", out_last, m_last);
      end
      c_id = '0; c_data = '0; c_resp = '0; c_last = 1'b0;
      if (exp_rdy != 0) begin
         c_id   = in_id[sel*IW +: IW];
         c_data = in_data[sel*DW +: DW];
         c_resp = in_resp[sel*RW +: RW];
         c_last = in_last[sel];
      end
      @(posedge clk);
      if (exp_rdy != 0) begin
         m_ov   = 1'b1;
         m_id   = c_id;
         m_data = c_data;
         m_resp = c_resp;
         m_last = c_last;
         m_own  = sel;
         seq[sel]++;
         if (c_last) begin
            m_lock    = 1'b0;
            m_ptr     = (sel + 1) % N;
            pend[sel]--;
            bidx[sel] = 0;
            blen[sel] = pick_len(sel);
         end else begin
            m_lock = 1'b1;
            bidx[sel]++;
         end
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
      #1;
   endtask

   task automatic drain(input int maxc);
      int c;
      c = 0;
      while (c < maxc && (any_pend() || m_ov)) begin
         step();
         c++;
      end
      check_eq("drain_done", {62'd0, any_pend(), m_ov}, 64'd0);
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         seq[i] = 0;
         set_src(i, 0, 1);
      end
      model_reset();
      out_ready = 1'b1;

      // Reset held with every source requesting.
      for (int i = 0; i < N; i++) set_src(i, 3, 1);
      drive_inputs();
      #2;
      check_eq("rst_in_ready", in_ready, 4'b0000);
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_owner", owner, 2'd0);
      check_eq("rst_out_id", out_id, 32'd0);
      check_eq("rst_out_last", out_last, 1'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      #1 check_eq("first_grant", in_ready, 4'b0001);

      // Round-robin over single-beat bursts.
      repeat (12) step();
      drain(20);

      // Burst lock: src1 four beats while src2 waits.
      set_src(1, 1, 4);
      set_src(2, 1, 1);
      drain(20);

      // Backpressure mid-burst.
      set_src(0, 1, 4);
      step();
      step();
      out_ready = 1'b0;
      repeat (5) step();
      out_ready = 1'b1;
      drain(20);

      // Owner stall: src3 drops valid between beats 2 and 3, src0 starved meanwhile.
      set_src(3, 1, 4);
      set_src(0, 1, 1);
      step();
      step();
      gate[3] = 1'b0;
      repeat (3) step();
      gate[3] = 1'b1;
      drain(20);

      // Pointer wrap after src3, then reset during the second beat of the next burst.
      set_src(3, 1, 1);
      drain(10);
      set_src(0, 1, 4);
      set_src(1, 1, 1);
      step();
      step();
      rst = 1'b0;
      #1;
      check_eq("mid_rst_busy", busy, 1'b0);
      check_eq("mid_rst_out_valid", out_valid, 1'b0);
      check_eq("mid_rst_in_ready", in_ready, 4'b0000);
      model_reset();
      for (int i = 0; i < N; i++) set_src(i, 0, 1);
      set_src(1, 1, 1);
      set_src(0, 1, 1);
      drive_inputs();
      @(posedge clk);
      #1 rst = 1'b1;
      #1 check_eq("restart_grant", in_ready, 4'b0001);
      drain(10);

      // Randomized traffic.
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < N; i++) begin
            gate[i] = ($urandom_range(9, 0) < 7);
            if (pend[i] == 0) begin
               pend[i]    = int'($urandom_range(3, 1));
               fix_len[i] = 0;
               blen[i]    = pick_len(i);
               bidx[i]    = 0;
            end
         end
         out_ready = ($urandom_range(3, 0) != 0);
         step();
      end
      out_ready = 1'b1;
      gate      = '1;
      drain(200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
